truth_table_capture: RTL

// - Sequential harness stage that drives a 7-input single-output combinational function
//   (majority-gate network) through all 2**N_INPUTS input vectors.
// - Samples the function output for each vector and packs the results into one truth-table word.
// - The function sits between fn_x and fn_out; this block feeds its inputs and consumes its output.
// - The completed word goes out over a valid/ready handshake to the classification/logging stage.

---
 rtl/truth_table_capture_pkg.sv | 14 +
 rtl/truth_table_capture_if.sv | 34 +++
 rtl/truth_table_capture_sequencer.sv | 50 +++++
 rtl/truth_table_capture.sv | 91 +++++++++
 4 files changed

// File: rtl/truth_table_capture_pkg.sv
// Shared types and sizing helpers for the truth-table capture harness.
// Optional macro SIG_CHECK_EN enables the signature comparator in the top level.
package tt_capture_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} tt_state_e;

   localparam int N_INPUTS_DEF = 7;
   localparam int SETTLE_MAX   = 15;

   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/truth_table_capture_if.sv
// Truth-table output handshake from the capture stage to the classification/logging stage.
// The match flag exists only when SIG_CHECK_EN is defined.
interface truth_table_capture_if
   import tt_capture_pkg::*;
#(
   parameter int TT_W = tt_width(N_INPUTS_DEF)
) ();

   logic            tt_valid;
   logic            tt_ready;
   logic [TT_W-1:0] tt_data;
`ifdef SIG_CHECK_EN
   logic            match;
`endif

   modport master (
      output tt_valid,
      output tt_data,
`ifdef SIG_CHECK_EN
      output match,
`endif
      input  tt_ready
   );

   modport slave (
      input  tt_valid,
      input  tt_data,
`ifdef SIG_CHECK_EN
      input  match,
`endif
      output tt_ready
   );

endinterface

// File: rtl/truth_table_capture_sequencer.sv
// Vector sequencer: walks idx through 0..TT_W-1, holding each vector for
// SETTLE_CYCLES extra cycles before raising the sample strobe.
module tt_vector_sequencer
   import tt_capture_pkg::*;
#(
   parameter int N_INPUTS      = N_INPUTS_DEF,
   parameter int SETTLE_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                run,
   output logic [N_INPUTS-1:0] fn_x,
   output logic                sample,
   output logic                last
);

   localparam int TT_W = tt_width(N_INPUTS);
   localparam int IW   = N_INPUTS + 1;
   localparam int SW   = $clog2(SETTLE_MAX + 1);

   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
   localparam logic [IW-1:0] LAST_IDX  = IW'(TT_W - 1);

   logic [IW-1:0] idx_q;
   logic [SW-1:0] settle_q;

   // idx stops on the last vector instead of wrapping; the FSM leaves DRIVE there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         settle_q <= '0;
      end else if (load) begin
         idx_q    <= '0;
         settle_q <= SETTLE_LD;
      end else if (run) begin
         if (settle_q != '0) begin
            settle_q <= settle_q - 1'b1;
         end else if (!last) begin
            idx_q    <= idx_q + 1'b1;
            settle_q <= SETTLE_LD;
         end
      end
   end

   assign sample = run && (settle_q == '0);
   assign last   = (idx_q == LAST_IDX);
   assign fn_x   = idx_q[N_INPUTS-1:0];

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps a combinational function over all input vectors and hands out its truth table.
// Define SIG_CHECK_EN to add the EXPECTED comparator and the match flag.
module truth_table_capture
   import tt_capture_pkg::*;
#(
   parameter int N_INPUTS      = N_INPUTS_DEF,
   parameter int SETTLE_CYCLES = 0
`ifdef SIG_CHECK_EN
   ,
   parameter logic [tt_width(N_INPUTS)-1:0] EXPECTED = '0
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic [N_INPUTS-1:0]   fn_x,
   input  logic                  fn_out,
   truth_table_capture_if.master tt
);

   localparam int TT_W = tt_width(N_INPUTS);

   tt_state_e       state_q, state_d;
   logic            load, run, sample, last, handshake;
   logic [TT_W-1:0] tt_q, tt_next;

   tt_vector_sequencer #(
      .N_INPUTS      (N_INPUTS),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .run    (run),
      .fn_x   (fn_x),
      .sample (sample),
      .last   (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE:    if (start) begin
                     state_d = DRIVE;
                     load    = 1'b1;
                  end
         DRIVE:   if (sample && last) state_d = DONE;
         DONE:    if (tt.tt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign run       = (state_q == DRIVE);
   assign busy      = (state_q != IDLE);
   assign handshake = (state_q == DONE) && tt.tt_ready;

   // Unwritten bits keep the previous sweep's values; only valid in DONE.
   always_comb begin
      tt_next = tt_q;
      if (sample) tt_next[fn_x] = fn_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tt_q <= '0;
      else        tt_q <= tt_next;
   end

   assign tt.tt_valid = (state_q == DONE);
   assign tt.tt_data  = tt_q;

`ifdef SIG_CHECK_EN
   logic match_q;

   // Compare the table including the final bit so match lines up with tt_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              match_q <= 1'b0;
      else if (sample && last) match_q <= (tt_next == EXPECTED);
      else if (handshake)      match_q <= 1'b0;
   end

   assign tt.match = match_q;
`endif

endmodule
